// File: rtl/shift_frame_pkg.sv
// Shared types and sizing constants for the shift-register frame sequencer.
package shift_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        GAP    = 3'd3,
        PARITY = 3'd4
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/shift_frame_fifo.sv
// Two-entry word buffer between the input handshake and the frame sequencer.
module shift_frame_fifo
    import shift_frame_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    output logic [BITS-1:0] head,
    output logic            full,
    output logic            empty
);

    logic [BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer for the parallel-load / serial-out shifter: buffers words,
// strobes load/shift, brackets frames and inserts gaps. Option: SHIFT_FRAME_PARITY_EN.
module shift_frame_ctrl
    import shift_frame_pkg::*;
#(
    parameter int BITS = 8,
    parameter int GAPW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [GAPW-1:0] gap_cfg,
    output logic            sr_load,
    output logic [BITS-1:0] sr_data,
    output logic            sr_shift,
    output logic            frame_active,
    output logic            done,
    output logic            busy
`ifdef SHIFT_FRAME_PARITY_EN
    ,
    output logic            parity_bit
`endif
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

    state_t          state;
    state_t          state_next;
    state_t          after_frame;
    logic [CW-1:0]   bit_cnt;
    logic [GAPW-1:0] gap_cnt;
    logic            ready_en;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [BITS-1:0] fifo_head;
`ifdef SHIFT_FRAME_PARITY_EN
    logic [BITS-1:0] word_q;
`endif

    // in_ready stays low through reset and comes up on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready  = ready_en & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign fifo_pop  = (state == LOAD);

    shift_frame_fifo #(
        .BITS (BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        after_frame = fifo_empty ? IDLE : LOAD;
        if (gap_cnt != '0) begin
            after_frame = GAP;
        end
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SHIFT;
            SHIFT: begin
                if (bit_cnt == '0) begin
`ifdef SHIFT_FRAME_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = after_frame;
`endif
                end
            end
`ifdef SHIFT_FRAME_PARITY_EN
            PARITY: state_next = after_frame;
`endif
            GAP: begin
                if (gap_cnt <= GAPW'(1)) begin
                    state_next = fifo_empty ? IDLE : LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // gap length is captured at LOAD so later gap_cfg edits only hit the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
            word_q  <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    bit_cnt <= LAST_BIT;
                    gap_cnt <= gap_cfg;
`ifdef SHIFT_FRAME_PARITY_EN
                    word_q  <= fifo_head;
`endif
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAPW'(1);
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt;
                    gap_cnt <= gap_cnt;
                end
            endcase
        end
    end

    assign sr_load  = (state == LOAD);
    assign sr_data  = sr_load ? fifo_head : '0;
    assign sr_shift = (state == SHIFT);
    assign busy     = (state != IDLE) | ~fifo_empty;

`ifdef SHIFT_FRAME_PARITY_EN
    assign frame_active = (state == SHIFT) | (state == PARITY);
    assign done         = (state == PARITY);
    assign parity_bit   = (state == PARITY) & (^word_q);
`else
    assign frame_active = (state == SHIFT);
    assign done         = (state == SHIFT) & (bit_cnt == '0);
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed scoreboard bench for shift_frame_ctrl; accepted words are queued and
// matched against sr_data at each load, frame timing is checked by a monitor.
module tb_shift_frame_ctrl;

    localparam int BITS = 8;
    localparam int GAPW = 4;
`ifdef SHIFT_FRAME_PARITY_EN
    localparam int FLEN = BITS + 1;
`else
    localparam int FLEN = BITS;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [BITS-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [GAPW-1:0] gap_cfg;
    logic            sr_load;
    logic [BITS-1:0] sr_data;
    logic            sr_shift;
    logic            frame_active;
    logic            done;
    logic            busy;
`ifdef SHIFT_FRAME_PARITY_EN
    logic            parity_bit;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int loads  = 0;
    int pushes = 0;
    int fa_cnt = 0;
    logic [BITS-1:0] sb [$];
    int              load_cyc [$];
    logic [31:0]     mon_exp;

    shift_frame_ctrl #(
        .BITS (BITS),
        .GAPW (GAPW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .gap_cfg      (gap_cfg),
        .sr_load      (sr_load),
        .sr_data      (sr_data),
        .sr_shift     (sr_shift),
        .frame_active (frame_active),
        .done         (done),
        .busy         (busy)
`ifdef SHIFT_FRAME_PARITY_EN
        ,
        .parity_bit   (parity_bit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every load; frame length, done and shift placement per cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            fa_cnt = 0;
        end else begin
            if (sr_load) begin
                if (sb.size() > 0) mon_exp = 32'(sb.pop_front());
                else mon_exp = 'x;
                check_output("sb_load_word", 32'(sr_data), mon_exp);
                load_cyc.push_back(cyc);
                loads++;
                fa_cnt = 0;
            end else begin
                check_output("sr_data_zero", 32'(sr_data), 0);
            end
            if (frame_active) begin
                fa_cnt++;
                check_output("done_position", 32'(done), 32'(fa_cnt == FLEN));
                check_output("shift_enable", 32'(sr_shift), 32'(fa_cnt <= BITS));
            end else begin
                check_output("done_outside_frame", 32'(done), 0);
                check_output("shift_outside_frame", 32'(sr_shift), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [BITS-1:0] w);
        logic rs;
        logic ok;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            rs = in_ready;
            step();
            if (rs) begin
                sb.push_back(w);
                pushes++;
                ok = 1'b1;
            end
        end
        check_output("push_accepted", 32'(ok), 1);
    endtask

    task automatic wait_loads(input int n);
        for (int i = 0; i < 200 && loads < n; i++) step();
        check_output("load_reached", 32'(loads >= n), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step();
        check_output("idle_busy", 32'(busy), 0);
    endtask

    task automatic count_frame(output int cnt);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_active) cnt++;
            else if (cnt > 0) break;
        end
    endtask

`ifdef SHIFT_FRAME_PARITY_EN
    task automatic parity_frame(input logic [BITS-1:0] w);
        logic pexp;
        int   cnt;
        pexp = ^w;
        push_word(w);
        in_valid = 1'b0;
        step();
        check_output("par_load", 32'(sr_load), 1);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_active) begin
                cnt++;
                if (cnt == FLEN) begin
                    check_output("parity_value", 32'(parity_bit), 32'(pexp));
                    check_output("parity_done", 32'(done), 1);
                end
            end else if (cnt > 0) begin
                break;
            end
        end
        check_output("par_frame_len", cnt, FLEN);
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stim
        int n;
        int base;
        int gc;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        gap_cfg  = '0;
        #1;
        check_output("rst_in_ready", 32'(in_ready), 0);
        check_output("rst_outputs", {sr_load, sr_shift, frame_active, done, busy}, 0);
        check_output("rst_sr_data", 32'(sr_data), 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        #1;
        check_output("ready_before_edge", 32'(in_ready), 0);
        step();
        check_output("ready_after_release", 32'(in_ready), 1);

        $display("[TB] single word");
        push_word(8'hA5);
        in_valid = 1'b0;
        check_output("lat_not_yet", 32'(sr_load), 0);
        check_output("busy_queued", 32'(busy), 1);
        step();
        check_output("lat_load", 32'(sr_load), 1);
        check_output("lat_data", 32'(sr_data), 32'hA5);
        count_frame(n);
        check_output("frame_len", n, FLEN);
        check_output("single_idle", 32'(busy), 0);

        $display("[TB] back-to-back");
        base = load_cyc.size();
        push_word(8'h01);
        push_word(8'h02);
        check_output("ready_full", 32'(in_ready), 0);
        push_word(8'h03);
        in_valid = 1'b0;
        wait_loads(base + 3);
        wait_idle();
        check_output("b2b_spacing_1", load_cyc[base+1] - load_cyc[base], FLEN + 1);
        check_output("b2b_spacing_2", load_cyc[base+2] - load_cyc[base+1], FLEN + 1);
        check_output("b2b_sb_empty", sb.size(), 0);

        $display("[TB] gap");
        gap_cfg = 4'd3;
        push_word(8'hC1);
        push_word(8'hD2);
        in_valid = 1'b0;
        repeat (3) step();
        gap_cfg = 4'd7;
        for (int i = 0; i < 32 && !done; i++) step();
        check_output("gap_done_seen", 32'(done), 1);
        gc = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (sr_load) break;
            check_output("gap_quiet", {sr_shift, frame_active, done}, 0);
            gc++;
        end
        check_output("gap_len_3", gc, 3);
        for (int i = 0; i < 32 && !done; i++) step();
        gc = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (!busy) break;
            gc++;
        end
        check_output("gap_len_7", gc, 7);
        gap_cfg = '0;

        $display("[TB] full fifo");
        push_word(8'h11);
        in_valid = 1'b0;
        for (int i = 0; i < 16 && !frame_active; i++) step();
        push_word(8'h22);
        push_word(8'h33);
        check_output("full_ready_low", 32'(in_ready), 0);
        in_data = 8'h44;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("full_hold_ready", 32'(in_ready), 0);
        end
        push_word(8'h44);
        in_valid = 1'b0;
        wait_idle();
        check_output("push_load_count", loads, pushes);
        check_output("full_sb_empty", sb.size(), 0);

        $display("[TB] reset mid-frame");
        push_word(8'h5A);
        in_valid = 1'b0;
        wait_loads(loads + 1);
        push_word(8'h6B);
        in_valid = 1'b0;
        repeat (2) step();
        check_output("pre_reset_active", 32'(frame_active), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_outputs", {sr_load, sr_shift, frame_active, done, busy, in_ready}, 0);
        check_output("abort_sr_data", 32'(sr_data), 0);
        sb.delete();
        step();
        check_output("abort_hold", {sr_load, sr_shift, frame_active, done, busy}, 0);
        #3 rst_n = 1'b1;
        step();
        check_output("post_rst_ready", 32'(in_ready), 1);
        check_output("post_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("post_rst_no_load", {sr_load, frame_active}, 0);
        end

`ifdef SHIFT_FRAME_PARITY_EN
        $display("[TB] parity");
        parity_frame(8'h07);
        parity_frame(8'h03);
        wait_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
